rowbias_pool: RTL and testbench

- Parametrised successor to the single-row bias bus: holds a pool of LEN distinct one-hot values in a random permutation.
- The permutation is generated in hardware after every reset, and again on demand, by an LFSR-driven Fisher-Yates shuffle.
- Serves NCH independent row channels. Each channel latches pool[k] onto its bus when its tiles request one-hot index k.
- Sits between the grid-generation controller (reshuffle/seed) and the per-row tile arrays (update/rqindex/busvalue).

---
 rtl/rowbias_pool.sv | 80 ++++++++
 tb/tb_rowbias_pool.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/rowbias_pool.sv
// rowbias_pool: LFSR Fisher-Yates shuffled pool of LEN one-hots served to NCH row buses
// Ports:
//   clock, reset (async active-low)
//   reshuffle, seed_load, seed[15:0] : pool control, sampled only while ready
//   ready, shuffle_done              : pool stable / one-cycle pulse on shuffle completion
//   update[NCH], rqindex[NCH*LEN]    : per-channel latch strobe and requested one-hot index
//   busvalue[NCH*LEN]                : per-channel registered bus, channel c at [c*LEN +: LEN]
module rowbias_pool #(
    parameter int LEN = 9,
    parameter int NCH = 9,
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               reshuffle,
    input  logic               seed_load,
    input  logic [15:0]        seed,
    output logic               ready,
    output logic               shuffle_done,
    input  logic [NCH-1:0]     update,
    input  logic [NCH*LEN-1:0] rqindex,
    output logic [NCH*LEN-1:0] busvalue
);
    localparam int CW = $clog2(LEN);
    typedef enum logic {IDLE, SHUFFLE} state_t;
    state_t         state;
    logic [LEN-1:0] pool [LEN];
    logic [15:0]    lfsr, lfsr_next;
    logic [CW-1:0]  i, j;
    assign j = lfsr[CW-1:0];
    assign lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    // candidates above i are rejected, so the shuffle length depends on the LFSR stream
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < LEN; k++) pool[k] <= LEN'(1) << k;
            lfsr         <= SEED;
            i            <= CW'(LEN - 1);
            state        <= SHUFFLE;
            ready        <= 1'b0;
            shuffle_done <= 1'b0;
        end else begin
            shuffle_done <= 1'b0;
            if (state == SHUFFLE) begin
                lfsr <= lfsr_next;
                if (j <= i) begin
                    pool[i] <= pool[j];
                    pool[j] <= pool[i];
                    if (i == CW'(1)) begin
                        state        <= IDLE;
                        ready        <= 1'b1;
                        shuffle_done <= 1'b1;
                    end else begin
                        i <= i - CW'(1);
                    end
                end
            end else begin
                // a zero seed would lock the LFSR up, so fall back to SEED
                if (seed_load) lfsr <= (seed == 16'h0000) ? SEED : seed;
                if (reshuffle) begin
                    state <= SHUFFLE;
                    i     <= CW'(LEN - 1);
                    ready <= 1'b0;
                end
            end
        end
    end
    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [LEN-1:0] sel, bus_q;
        // lowest set request bit wins; an all-zero request selects zero
        always_comb begin
            sel = '0;
            for (int k = LEN - 1; k >= 0; k--) if (rqindex[c*LEN + k]) sel = pool[k];
        end
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) bus_q <= '0;
            else if (update[c] && ready) bus_q <= sel;
        end
        assign busvalue[c*LEN +: LEN] = bus_q;
    end
endmodule

// File: tb/tb_rowbias_pool.sv
// tb_rowbias_pool: scoreboard bench for rowbias_pool (LEN=9, NCH=9 plus an NCH=3 instance)
module tb_rowbias_pool;
    localparam int LEN = 9;
    localparam int NCH = 9;
    localparam int NCH2 = 3;
    localparam logic [15:0] SEED = 16'hACE1;

    logic clock = 1'b0, reset = 1'b0, reshuffle = 1'b0, seed_load = 1'b0;
    logic [15:0] seed = '0;
    logic ready, shuffle_done, ready2, done2;
    logic [NCH-1:0] update = '0;
    logic [NCH*LEN-1:0] rqindex = '0, busvalue;
    logic [NCH2-1:0] update2 = '0;
    logic [NCH2*LEN-1:0] rqindex2 = '0, busvalue2;

    rowbias_pool #(.LEN(LEN), .NCH(NCH), .SEED(SEED)) dut (
        .clock(clock), .reset(reset), .reshuffle(reshuffle), .seed_load(seed_load), .seed(seed),
        .ready(ready), .shuffle_done(shuffle_done), .update(update), .rqindex(rqindex), .busvalue(busvalue)
    );
    rowbias_pool #(.LEN(LEN), .NCH(NCH2), .SEED(SEED)) dut2 (
        .clock(clock), .reset(reset), .reshuffle(reshuffle), .seed_load(seed_load), .seed(seed),
        .ready(ready2), .shuffle_done(done2), .update(update2), .rqindex(rqindex2), .busvalue(busvalue2)
    );

    always #5 clock = ~clock;
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // kind: 0 = dut bus channel, 1 = ready, 2 = shuffle_done, 3 = dut2 bus channel
    typedef struct {
        int             due;
        int             kind;
        int             ch;
        logic [LEN-1:0] exp;
        string          nm;
    } exp_t;
    exp_t q[$];
    int vectors = 0, miscompares = 0;

    // first permutation from SEED, worked out by hand: pool[k] = 1 << hand[k]
    int hand[LEN] = '{7, 6, 5, 8, 2, 4, 3, 0, 1};
    int m_pool[LEN];
    logic [15:0] m_lfsr;

    function automatic logic [LEN-1:0] oh(int k);
        return LEN'(1) << k;
    endfunction

    function automatic void push(int due, int kind, int ch, logic [LEN-1:0] exp, string nm);
        exp_t e;
        e.due = due; e.kind = kind; e.ch = ch; e.exp = exp; e.nm = nm;
        q.push_back(e);
    endfunction

    // reference shuffle on the model pool; returns the number of SHUFFLE cycles
    function automatic int model_shuffle();
        int i = LEN - 1, n = 0, j, t;
        while (n < 4000) begin
            j = int'(m_lfsr[3:0]);
            m_lfsr = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
            n++;
            if (j <= i) begin
                t = m_pool[i]; m_pool[i] = m_pool[j]; m_pool[j] = t;
                if (i == 1) break;
                i--;
            end
        end
        return n;
    endfunction

    always @(negedge clock) begin
        for (int x = 0; x < q.size(); ) begin
            if (q[x].due <= cyc) begin
                exp_t e;
                logic [LEN-1:0] act;
                e = q[x];
                q.delete(x);
                act = e.kind == 0 ? busvalue[e.ch*LEN +: LEN] :
                      e.kind == 1 ? LEN'(ready) :
                      e.kind == 2 ? LEN'(shuffle_done) : busvalue2[e.ch*LEN +: LEN];
                vectors++;
                if (act !== e.exp) begin
                    miscompares++;
                    $display("FAIL %s ch%0d cycle %0d: got %h, expected %h", e.nm, e.ch, cyc, act, e.exp);
                end
            end else begin
                x++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_shuffle(int start, int n);
        for (int t = 0; t < n; t++) push(start + t, 1, 0, '0, "ready_low");
        push(start + n, 1, 0, LEN'(1), "ready_high");
        push(start + n, 2, 0, LEN'(1), "done_pulse");
        push(start + n + 1, 2, 0, '0, "done_clear");
    endtask

    task automatic do_reset();
        int n;
        tick();
        reset = 1'b0;
        push(cyc, 1, 0, '0, "rst_ready");
        push(cyc, 2, 0, '0, "rst_done");
        for (int c = 0; c < NCH; c++) push(cyc, 0, c, '0, "rst_bus");
        for (int c = 0; c < NCH2; c++) push(cyc, 3, c, '0, "rst_bus2");
        tick();
        tick();
        reset = 1'b1;
        for (int k = 0; k < LEN; k++) m_pool[k] = k;
        m_lfsr = SEED;
        n = model_shuffle();
        expect_shuffle(cyc, n);
        repeat (n) tick();
    endtask

    task automatic do_shuffle(input logic ld, input logic [15:0] sv);
        int n;
        reshuffle = 1'b1;
        seed_load = ld;
        seed = sv;
        if (ld) m_lfsr = (sv == 16'h0000) ? SEED : sv;
        n = model_shuffle();
        expect_shuffle(cyc + 1, n);
        tick();
        reshuffle = 1'b0;
        seed_load = 1'b0;
        repeat (n) tick();
    endtask

    task automatic upd(int ch, logic [LEN-1:0] raw, logic [LEN-1:0] exp, string nm);
        update[ch] = 1'b1;
        rqindex[ch*LEN +: LEN] = raw;
        push(cyc + 1, 0, ch, exp, nm);
        tick();
        update[ch] = 1'b0;
    endtask

    task automatic sweep(int ch, logic use_hand);
        for (int k = 0; k < LEN; k++)
            upd(ch, oh(k), oh(use_hand ? hand[k] : m_pool[k]), $sformatf("sweep_ch%0d_k%0d", ch, k));
    endtask

    initial begin
        int n, r;
        logic [LEN-1:0] old;
        do_reset();
        sweep(0, 1'b1);

        upd(2, 9'b000000100, oh(hand[2]), "ch2_onehot");
        upd(2, 9'b000000000, '0, "ch2_zero");
        upd(2, 9'b000010100, oh(hand[2]), "ch2_multi_lowest");

        upd(0, oh(3), oh(m_pool[3]), "ch0_pool3");
        old = oh(m_pool[3]);
        reshuffle = 1'b1;
        r = cyc;
        n = model_shuffle();
        expect_shuffle(r + 1, n);
        for (int t = 1; t <= n + 1; t++) push(r + t, 0, 0, old, "hold_during_shuffle");
        push(r + n + 2, 0, 0, oh(m_pool[5]), "first_after_ready");
        tick();
        reshuffle = 1'b0;
        update[0] = 1'b1;
        rqindex[0 +: LEN] = oh(5);
        for (int t = 0; t < n + 1; t++) begin
            if (t == 2) begin reshuffle = 1'b1; seed_load = 1'b1; seed = 16'h5555; end
            if (t == 3) begin reshuffle = 1'b0; seed_load = 1'b0; end
            tick();
        end
        update[0] = 1'b0;
        sweep(1, 1'b0);

        update2 = 3'b111;
        rqindex2 = {3{oh(8)}};
        for (int c = 0; c < NCH2; c++) push(cyc + 1, 3, c, oh(m_pool[8]), "n3_all_p8");
        tick();
        update2 = 3'b101;
        rqindex2 = {oh(2), oh(1), oh(0)};
        push(cyc + 1, 3, 0, oh(m_pool[0]), "n3_ch0_p0");
        push(cyc + 1, 3, 1, oh(m_pool[8]), "n3_ch1_hold");
        push(cyc + 1, 3, 2, oh(m_pool[2]), "n3_ch2_p2");
        tick();
        update2 = '0;

        reshuffle = 1'b1;
        r = cyc;
        for (int t = 1; t <= 3; t++) push(r + t, 1, 0, '0, "ready_low_mid");
        tick();
        reshuffle = 1'b0;
        tick();
        tick();
        do_reset();
        sweep(3, 1'b1);

        do_shuffle(1'b1, 16'h0000);
        sweep(4, 1'b0);

        do_reset();
        do_shuffle(1'b1, 16'h1234);
        sweep(5, 1'b0);
        do_reset();
        do_shuffle(1'b1, 16'h1234);
        sweep(6, 1'b0);

        repeat (3) tick();
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL queue_drain: %0d expectations left, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
